// File: rtl/alu_decode_stage_if.sv
// rtl/alu_decode_stage_if.sv - fetch-side input and execute-side output bundle of the decode stage
interface alu_decode_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  alu_control;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        illegal;

    modport master (
        output in_valid, instr, rs1_data, rs2_data, out_ready,
        input  in_ready, out_valid, alu_control, op_a, op_b, imm, rd,
               reg_write, mem_read, mem_write, branch, illegal
    );

    modport slave (
        input  in_valid, instr, rs1_data, rs2_data, out_ready,
        output in_ready, out_valid, alu_control, op_a, op_b, imm, rd,
               reg_write, mem_read, mem_write, branch, illegal
    );
endinterface

// File: rtl/alu_decode_stage.sv
// rtl/alu_decode_stage.sv - registered RV32I decode stage feeding the ALU
// Optional BEQ/BNE decode enabled by defining ALU_BRANCH_EN.
module alu_decode_stage (
    input logic              clk,
    input logic              rst,
    input logic              flush,
    alu_decode_stage_if.slave bus
);
    localparam logic [3:0] alu_add     = 4'b0000;
    localparam logic [3:0] alu_and     = 4'b0001;
    localparam logic [3:0] alu_or      = 4'b0010;
    localparam logic [3:0] alu_sll     = 4'b0011;
    localparam logic [3:0] alu_slt     = 4'b0100;
    localparam logic [3:0] alu_srl     = 4'b0101;
    localparam logic [3:0] alu_sub     = 4'b0110;
    localparam logic [3:0] alu_xor     = 4'b0111;
    localparam logic [3:0] alu_illegal = 4'b1111;

    localparam logic [6:0] op_r      = 7'b0110011;
    localparam logic [6:0] op_i      = 7'b0010011;
    localparam logic [6:0] op_load   = 7'b0000011;
    localparam logic [6:0] op_store  = 7'b0100011;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] i_imm;
    logic [31:0] s_imm;

    assign opcode = bus.instr[6:0];
    assign funct3 = bus.instr[14:12];
    assign funct7 = bus.instr[31:25];
    assign i_imm  = {{20{bus.instr[31]}}, bus.instr[31:20]};
    assign s_imm  = {{20{bus.instr[31]}}, bus.instr[31:25], bus.instr[11:7]};

`ifdef ALU_BRANCH_EN
    localparam logic [6:0] op_branch = 7'b1100011;
    localparam logic [3:0] alu_beq   = 4'b1000;
    localparam logic [3:0] alu_bne   = 4'b1001;
    logic [31:0] b_imm;
    assign b_imm = {{19{bus.instr[31]}}, bus.instr[31], bus.instr[7],
                    bus.instr[30:25], bus.instr[11:8], 1'b0};
`endif

    // Source-register indices are resolved by the register file before this stage.
    logic unused_rs1_idx;
    assign unused_rs1_idx = ^bus.instr[19:15];

    logic [3:0]  d_ctl;
    logic [31:0] d_a, d_b, d_imm;
    logic [4:0]  d_rd;
    logic        d_legal, d_wr, d_mr, d_mw, d_br;

    always_comb begin
        d_ctl   = alu_add;
        d_a     = bus.rs1_data;
        d_b     = bus.rs2_data;
        d_imm   = '0;
        d_rd    = bus.instr[11:7];
        d_legal = 1'b0;
        d_wr    = 1'b0;
        d_mr    = 1'b0;
        d_mw    = 1'b0;
        d_br    = 1'b0;
        case (opcode)
            op_r: begin
                d_wr = 1'b1;
                if (funct7 == 7'b0000000) begin
                    d_legal = 1'b1;
                    case (funct3)
                        3'b000:  d_ctl = alu_add;
                        3'b001:  d_ctl = alu_sll;
                        3'b010:  d_ctl = alu_slt;
                        3'b100:  d_ctl = alu_xor;
                        3'b101:  d_ctl = alu_srl;
                        3'b110:  d_ctl = alu_or;
                        3'b111:  d_ctl = alu_and;
                        default: d_legal = 1'b0;
                    endcase
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    d_legal = 1'b1;
                    d_ctl   = alu_sub;
                end
            end
            op_i: begin
                d_wr    = 1'b1;
                d_b     = i_imm;
                d_imm   = i_imm;
                d_legal = 1'b1;
                case (funct3)
                    3'b000: d_ctl = alu_add;
                    3'b010: d_ctl = alu_slt;
                    3'b100: d_ctl = alu_xor;
                    3'b110: d_ctl = alu_or;
                    3'b111: d_ctl = alu_and;
                    3'b001: begin
                        d_ctl   = alu_sll;
                        d_b     = {27'b0, bus.instr[24:20]};
                        d_legal = (funct7 == 7'b0000000);
                    end
                    3'b101: begin
                        d_ctl   = alu_srl;
                        d_b     = {27'b0, bus.instr[24:20]};
                        d_legal = (funct7 == 7'b0000000);
                    end
                    default: d_legal = 1'b0;
                endcase
            end
            op_load: begin
                d_legal = (funct3 == 3'b000) || (funct3 == 3'b010);
                d_b     = i_imm;
                d_imm   = i_imm;
                d_mr    = 1'b1;
                d_wr    = 1'b1;
            end
            op_store: begin
                d_legal = (funct3 == 3'b000) || (funct3 == 3'b010);
                d_b     = s_imm;
                d_imm   = s_imm;
                d_mw    = 1'b1;
            end
`ifdef ALU_BRANCH_EN
            op_branch: begin
                d_legal = (funct3 == 3'b000) || (funct3 == 3'b001);
                d_ctl   = funct3[0] ? alu_bne : alu_beq;
                d_imm   = b_imm;
                d_br    = 1'b1;
            end
`endif
            default: d_legal = 1'b0;
        endcase
        if (!d_legal) begin
            d_ctl = alu_illegal;
            d_wr  = 1'b0;
            d_mr  = 1'b0;
            d_mw  = 1'b0;
            d_br  = 1'b0;
        end
        if (d_rd == 5'd0) d_wr = 1'b0;
    end

    assign bus.in_ready = !flush && (!bus.out_valid || bus.out_ready);

    // Data fields only load on a transfer, so they stay bit-stable through a stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid   <= 1'b0;
            bus.alu_control <= '0;
            bus.op_a        <= '0;
            bus.op_b        <= '0;
            bus.imm         <= '0;
            bus.rd          <= '0;
            bus.reg_write   <= 1'b0;
            bus.mem_read    <= 1'b0;
            bus.mem_write   <= 1'b0;
            bus.branch      <= 1'b0;
            bus.illegal     <= 1'b0;
        end else if (flush) begin
            bus.out_valid <= 1'b0;
        end else if (bus.in_valid && bus.in_ready) begin
            bus.out_valid   <= 1'b1;
            bus.alu_control <= d_ctl;
            bus.op_a        <= d_a;
            bus.op_b        <= d_b;
            bus.imm         <= d_imm;
            bus.rd          <= d_rd;
            bus.reg_write   <= d_wr;
            bus.mem_read    <= d_mr;
            bus.mem_write   <= d_mw;
            bus.branch      <= d_br;
            bus.illegal     <= !d_legal;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_decode_stage.sv
// tb/tb_alu_decode_stage.sv - directed and randomized checks of alu_decode_stage against a mnemonic-level model
module tb_alu_decode_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   code_of[string];

    alu_decode_stage_if bus ();

    alu_decode_stage dut (
        .clk  (clk),
        .rst  (rst),
        .flush(flush),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  ctl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        wr, mr, mw, br, ill;
        logic        chk_data, chk_rd;
    } exp_t;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2);
        exp_t  e;
        string m;
        string cls;
        logic [6:0]  opc = ins[6:0];
        logic [2:0]  f3 = ins[14:12];
        logic [6:0]  f7 = ins[31:25];
        logic [11:0] i12 = ins[31:20];
        logic [11:0] s12 = {ins[31:25], ins[11:7]};
        logic [12:0] b13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        int    iimm = int'($signed(i12));
        int    simm = int'($signed(s12));
        int    bimm = int'($signed(b13));
        e = '0;
        m = "bad";
        cls = "X";
        if (opc == 7'h33) begin
            cls = "R";
            if (f7 == 7'h00) begin
                if (f3 == 0) m = "add";
                else if (f3 == 1) m = "sll";
                else if (f3 == 2) m = "slt";
                else if (f3 == 4) m = "xor";
                else if (f3 == 5) m = "srl";
                else if (f3 == 6) m = "or";
                else if (f3 == 7) m = "and";
            end else if (f7 == 7'h20 && f3 == 0) m = "sub";
        end else if (opc == 7'h13) begin
            cls = "I";
            if (f3 == 0) m = "addi";
            else if (f3 == 2) m = "slti";
            else if (f3 == 4) m = "xori";
            else if (f3 == 6) m = "ori";
            else if (f3 == 7) m = "andi";
            else if (f3 == 1 && f7 == 0) m = "slli";
            else if (f3 == 5 && f7 == 0) m = "srli";
        end else if (opc == 7'h03) begin
            cls = "L";
            if (f3 == 0) m = "lb";
            else if (f3 == 2) m = "lw";
        end else if (opc == 7'h23) begin
            cls = "S";
            if (f3 == 0) m = "sb";
            else if (f3 == 2) m = "sw";
        end
`ifdef ALU_BRANCH_EN
        else if (opc == 7'h63) begin
            cls = "B";
            if (f3 == 0) m = "beq";
            else if (f3 == 1) m = "bne";
        end
`endif
        if (m == "bad") begin
            e.ctl = 4'hF;
            e.ill = 1'b1;
            return e;
        end
        e.ctl = 4'(code_of[m]);
        e.a = r1;
        e.chk_data = 1'b1;
        e.rd = ins[11:7];
        if (cls == "R") begin
            e.b = r2;
            e.wr = (ins[11:7] != 0);
            e.chk_rd = 1'b1;
        end else if (cls == "I") begin
            e.b = (m == "slli" || m == "srli") ? 32'(ins[24:20]) : iimm;
            e.imm = iimm;
            e.wr = (ins[11:7] != 0);
            e.chk_rd = 1'b1;
        end else if (cls == "L") begin
            e.b = iimm;
            e.imm = iimm;
            e.mr = 1'b1;
            e.wr = (ins[11:7] != 0);
            e.chk_rd = 1'b1;
        end else if (cls == "S") begin
            e.b = simm;
            e.imm = simm;
            e.mw = 1'b1;
        end else begin
            e.b = r2;
            e.imm = bimm;
            e.br = 1'b1;
        end
        return e;
    endfunction

    task automatic check_bundle(input string tag, input exp_t e);
        check({tag, ".ctl"}, 32'(bus.alu_control), 32'(e.ctl));
        check({tag, ".ill"}, 32'(bus.illegal), 32'(e.ill));
        check({tag, ".wr"}, 32'(bus.reg_write), 32'(e.wr));
        check({tag, ".mr"}, 32'(bus.mem_read), 32'(e.mr));
        check({tag, ".mw"}, 32'(bus.mem_write), 32'(e.mw));
        check({tag, ".br"}, 32'(bus.branch), 32'(e.br));
        if (e.chk_data) begin
            check({tag, ".op_a"}, bus.op_a, e.a);
            check({tag, ".op_b"}, bus.op_b, e.b);
            check({tag, ".imm"}, bus.imm, e.imm);
        end
        if (e.chk_rd) check({tag, ".rd"}, 32'(bus.rd), 32'(e.rd));
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] r1,
                         input logic [31:0] r2, input logic ordy, input logic fl);
        bus.in_valid = v;
        bus.instr = ins;
        bus.rs1_data = r1;
        bus.rs2_data = r2;
        bus.out_ready = ordy;
        flush = fl;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w = $urandom;
        int k = $urandom_range(0, 6);
        int j = $urandom_range(0, 3);
        if (k == 0) w[6:0] = 7'h33;
        else if (k == 1) w[6:0] = 7'h13;
        else if (k == 2) w[6:0] = 7'h03;
        else if (k == 3) w[6:0] = 7'h23;
        else if (k == 4) w[6:0] = 7'h63;
        if (j == 0) w[31:25] = 7'h00;
        else if (j == 1) w[31:25] = 7'h20;
        return w;
    endfunction

    localparam logic [31:0] i_add  = 32'h002081B3;
    localparam logic [31:0] i_srli = 32'h0030D213;
    localparam logic [31:0] i_sw   = 32'hFE20AE23;
    localparam logic [31:0] i_bne  = 32'h00209863;
    localparam logic [31:0] i_addi = 32'h00100013;
    localparam logic [31:0] i_undef = 32'h0000007F;

    initial begin
        logic [3:0] bne_ctl;
        logic       bne_ill;
        logic       exp_valid;
        logic       exp_rdy;
        exp_t       exp_b;

        code_of["add"] = 0;  code_of["addi"] = 0; code_of["lb"] = 0; code_of["lw"] = 0;
        code_of["sb"] = 0;   code_of["sw"] = 0;   code_of["and"] = 1; code_of["andi"] = 1;
        code_of["or"] = 2;   code_of["ori"] = 2;  code_of["sll"] = 3; code_of["slli"] = 3;
        code_of["slt"] = 4;  code_of["slti"] = 4; code_of["srl"] = 5; code_of["srli"] = 5;
        code_of["sub"] = 6;  code_of["xor"] = 7;  code_of["xori"] = 7;
        code_of["beq"] = 8;  code_of["bne"] = 9;
`ifdef ALU_BRANCH_EN
        bne_ctl = 4'h9;
        bne_ill = 1'b0;
`else
        bne_ctl = 4'hF;
        bne_ill = 1'b1;
`endif

        drive(0, 0, 0, 0, 0, 0);
        tick;
        tick;
        check("reset.out_valid", 32'(bus.out_valid), 0);
        check("reset.ctl", 32'(bus.alu_control), 0);
        check("reset.op_a", bus.op_a, 0);
        check("reset.op_b", bus.op_b, 0);
        check("reset.imm", bus.imm, 0);
        check("reset.flags", 32'({bus.reg_write, bus.mem_read, bus.mem_write, bus.branch, bus.illegal}), 0);
        rst = 1'b0;

        drive(1, i_add, 5, 7, 1, 0);
        check("add.in_ready", 32'(bus.in_ready), 1);
        tick;
        check("add.out_valid", 32'(bus.out_valid), 1);
        check("add.ctl", 32'(bus.alu_control), 0);
        check("add.op_a", bus.op_a, 5);
        check("add.op_b", bus.op_b, 7);
        check("add.rd", 32'(bus.rd), 3);
        check("add.wr", 32'(bus.reg_write), 1);

        drive(1, i_srli, 32'h80, 0, 1, 0);
        tick;
        check("srli.ctl", 32'(bus.alu_control), 5);
        check("srli.op_b", bus.op_b, 3);
        check("srli.rd", 32'(bus.rd), 4);
        drive(1, i_sw, 100, 2, 1, 0);
        tick;
        check("sw.out_valid", 32'(bus.out_valid), 1);
        check("sw.ctl", 32'(bus.alu_control), 0);
        check("sw.op_b", bus.op_b, 32'hFFFFFFFC);
        check("sw.imm", bus.imm, 32'hFFFFFFFC);
        check("sw.mw", 32'(bus.mem_write), 1);
        check("sw.wr", 32'(bus.reg_write), 0);

        drive(1, i_bne, 1, 2, 1, 0);
        tick;
        check("bne.ctl", 32'(bus.alu_control), 32'(bne_ctl));
        check("bne.ill", 32'(bus.illegal), 32'(bne_ill));
        check("bne.br", 32'(bus.branch), 32'(!bne_ill));
`ifdef ALU_BRANCH_EN
        check("bne.imm", bus.imm, 16);
`endif

        // Stall three cycles with an ADD pending behind the held BNE bundle.
        drive(1, i_add, 9, 11, 0, 0);
        for (int i = 0; i < 3; i++) begin
            check("stall.in_ready", 32'(bus.in_ready), 0);
            tick;
            check("stall.out_valid", 32'(bus.out_valid), 1);
            check("stall.ctl", 32'(bus.alu_control), 32'(bne_ctl));
            check("stall.op_a", bus.op_a, 1);
            check("stall.op_b", bus.op_b, 2);
        end
        drive(1, i_add, 9, 11, 1, 0);
        check("release.in_ready", 32'(bus.in_ready), 1);
        tick;
        check("release.ctl", 32'(bus.alu_control), 0);
        check("release.op_a", bus.op_a, 9);
        check("release.op_b", bus.op_b, 11);

        drive(1, i_sw, 3, 4, 0, 1);
        check("flush.in_ready", 32'(bus.in_ready), 0);
        tick;
        check("flush.out_valid", 32'(bus.out_valid), 0);
        drive(0, 0, 0, 0, 1, 0);
        tick;
        check("flush.not_captured", 32'(bus.out_valid), 0);

        drive(1, i_addi, 0, 0, 1, 0);
        tick;
        check("addi_x0.ctl", 32'(bus.alu_control), 0);
        check("addi_x0.op_b", bus.op_b, 1);
        check("addi_x0.wr", 32'(bus.reg_write), 0);
        drive(1, i_undef, 0, 0, 1, 0);
        tick;
        check("undef.ctl", 32'(bus.alu_control), 4'hF);
        check("undef.ill", 32'(bus.illegal), 1);
        check("undef.wr", 32'(bus.reg_write), 0);
        drive(0, 0, 0, 0, 1, 0);
        tick;
        check("drain.out_valid", 32'(bus.out_valid), 0);

        drive(1, i_add, 5, 7, 0, 0);
        tick;
        check("pre_rst.out_valid", 32'(bus.out_valid), 1);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst.out_valid", 32'(bus.out_valid), 0);
        check("async_rst.ctl", 32'(bus.alu_control), 0);
        check("async_rst.op_a", bus.op_a, 0);
        #1;
        rst = 1'b0;

        exp_valid = 1'b0;
        exp_b = '0;
        for (int n = 0; n < 400; n++) begin
            logic        v = ($urandom_range(0, 3) != 0);
            logic        o = ($urandom_range(0, 2) != 0);
            logic        f = ($urandom_range(0, 15) == 0);
            logic [31:0] ins = rand_instr();
            logic [31:0] r1 = $urandom;
            logic [31:0] r2 = $urandom;
            drive(v, ins, r1, r2, o, f);
            exp_rdy = !f && (!exp_valid || o);
            check("rand.in_ready", 32'(bus.in_ready), 32'(exp_rdy));
            tick;
            if (f) exp_valid = 1'b0;
            else if (v && exp_rdy) begin
                exp_valid = 1'b1;
                exp_b = model(ins, r1, r2);
            end else if (o) exp_valid = 1'b0;
            check("rand.out_valid", 32'(bus.out_valid), 32'(exp_valid));
            if (exp_valid) check_bundle("rand", exp_b);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
